// File: rtl/fetch_skid_stage.sv
// rtl/fetch_skid_stage.sv - IF/ID pipeline stage with valid/ready handshake and two-entry skid buffer
module fetch_skid_stage #(
    parameter int                   PC_W         = 32,
    parameter int                   INSTR_W      = 32,
    parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = '0,
    parameter int                   CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               valid_in_i,
    output logic               ready_out_o,
    input  logic [PC_W-1:0]    pc_in_i,
    input  logic [INSTR_W-1:0] instr_in_i,
    output logic               valid_out_o,
    input  logic               ready_in_i,
    output logic [PC_W-1:0]    pc_out_o,
    output logic [INSTR_W-1:0] instr_out_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               acc, take;

    assign valid_out_o = (state_q != S_EMPTY);
    assign ready_out_o = ready_q;
    assign pc_out_o    = main_pc_q;
    assign instr_out_o = main_instr_q;
    assign stall_cnt_o = stall_cnt_q;

    assign acc  = valid_in_i & ready_q;
    assign take = valid_out_o & ready_in_i;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        stall_cnt_d  = stall_cnt_q;
        if (clr_i) begin
            state_d      = S_EMPTY;
            main_pc_d    = '0;
            main_instr_d = BUBBLE_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = BUBBLE_INSTR;
            stall_cnt_d  = '0;
        end else begin
            if (valid_out_o && !ready_in_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            unique case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        main_pc_d    = pc_in_i;
                        main_instr_d = instr_in_i;
                        state_d      = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (acc && take) begin
                        main_pc_d    = pc_in_i;
                        main_instr_d = instr_in_i;
                    end else if (acc) begin
                        skid_pc_d    = pc_in_i;
                        skid_instr_d = instr_in_i;
                        state_d      = S_FULL;
                    end else if (take) begin
                        // Bubble values live in MAIN so the outputs need no muxing.
                        main_pc_d    = '0;
                        main_instr_d = BUBBLE_INSTR;
                        state_d      = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (take) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        state_d      = S_BUSY;
                    end
                end
                default: begin
                    state_d      = S_EMPTY;
                    main_pc_d    = '0;
                    main_instr_d = BUBBLE_INSTR;
                end
            endcase
        end
        ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_EMPTY;
            ready_q      <= 1'b1;
            main_pc_q    <= '0;
            main_instr_q <= BUBBLE_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= BUBBLE_INSTR;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_skid_stage.sv
// tb/tb_fetch_skid_stage.sv - directed and random checks of fetch_skid_stage against a queue model
module tb_fetch_skid_stage;

    localparam int          PC_W    = 32;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] BUBBLE  = 32'h0000_0013;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic               clk, rst_n, clr, valid_in, ready_out, valid_out, ready_in;
    logic [PC_W-1:0]    pc_in, pc_out;
    logic [INSTR_W-1:0] instr_in, instr_out;
    logic [CNT_W-1:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the stage is a FIFO of capacity two whose head is on the outputs.
    logic [63:0] mq[$];
    int          mcnt = 0;

    fetch_skid_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .BUBBLE_INSTR(BUBBLE), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .valid_in_i(valid_in), .ready_out_o(ready_out),
        .pc_in_i(pc_in), .instr_in_i(instr_in),
        .valid_out_o(valid_out), .ready_in_i(ready_in),
        .pc_out_o(pc_out), .instr_out_o(instr_out),
        .stall_cnt_o(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic v;
        v = (mq.size() != 0);
        check({tag, ".valid"}, 64'(valid_out), 64'(v));
        check({tag, ".ready"}, 64'(ready_out), 64'(mq.size() < 2));
        check({tag, ".pc"},    64'(pc_out),    v ? 64'(mq[0][63:32]) : 64'd0);
        check({tag, ".instr"}, 64'(instr_out), v ? 64'(mq[0][31:0]) : 64'(BUBBLE));
        check({tag, ".cnt"},   64'(stall_cnt), 64'(mcnt));
    endtask

    task automatic step(input string tag);
        int sz;
        if (clr) begin
            mq.delete();
            mcnt = 0;
        end else begin
            sz = mq.size();
            if (sz > 0 && !ready_in && mcnt < CNT_MAX) mcnt++;
            if (sz > 0 && ready_in) void'(mq.pop_front());
            if (valid_in && sz < 2) mq.push_back({pc_in, instr_in});
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic r, input logic [31:0] pc);
        valid_in = v;
        ready_in = r;
        pc_in    = pc;
        instr_in = $urandom();
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        pc_in = '0; instr_in = '0;
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 32'(i));
            step("stream");
        end
        drive(1'b0, 1'b1, 32'd0);
        step("stream_drain");

        // Back-pressure into the skid entry
        drive(1'b1, 1'b1, 32'd10); step("bp10");
        drive(1'b1, 1'b0, 32'd11); step("bp11");
        check("bp_full_ready", 64'(ready_out), 64'd0);
        drive(1'b1, 1'b0, 32'd12); step("bp12_held");
        drive(1'b1, 1'b0, 32'd12); step("bp12_held2");
        drive(1'b1, 1'b1, 32'd12); step("bp_release");
        check("bp_out11", 64'(pc_out), 64'd11);
        drive(1'b1, 1'b1, 32'd12); step("bp12_acc");
        check("bp_out12", 64'(pc_out), 64'd12);
        drive(1'b0, 1'b1, 32'd0); step("bp_drain");

        // Flush from FULL with a pair on the input
        drive(1'b1, 1'b1, 32'd20); step("fl20");
        drive(1'b1, 1'b0, 32'd21); step("fl21");
        drive(1'b1, 1'b0, 32'd22); clr = 1'b1;
        step("flush");
        clr = 1'b0;
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_instr", 64'(instr_out), 64'(BUBBLE));
        check("flush_cnt",   64'(stall_cnt), 64'd0);
        drive(1'b0, 1'b1, 32'd0); step("flush_after");

        // Saturating stall counter
        drive(1'b1, 1'b0, 32'd30); step("sat_load");
        drive(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) step("sat");
        check("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        drive(1'b0, 1'b1, 32'd0); step("sat_drain");

        // Asynchronous reset while FULL
        drive(1'b1, 1'b0, 32'd40); step("ar40");
        drive(1'b1, 1'b0, 32'd41); step("ar41");
        drive(1'b0, 1'b0, 32'd0);
        #2 rst_n = 1'b0;
        mq.delete();
        mcnt = 0;
        #1 check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'd50); step("ar_first");
        check("ar_first_pc", 64'(pc_out), 64'd50);
        drive(1'b0, 1'b1, 32'd0); step("ar_drain");

        // Random traffic; READY_OUT must not follow READY_IN within a cycle
        for (int i = 0; i < 10000; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 63) == 0);
            if (valid_in) begin
                pc_in    = $urandom();
                instr_in = $urandom();
            end else begin
                pc_in    = 'x;
                instr_in = 'x;
            end
            if (i % 16 == 0) begin
                #1 check("rnd_ready_comb_a", 64'(ready_out), 64'(mq.size() < 2));
                ready_in = ~ready_in;
                #1 check("rnd_ready_comb_b", 64'(ready_out), 64'(mq.size() < 2));
                ready_in = ~ready_in;
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
